iir_out_checker: RTL

Synthesizable output-side checker for the IIR filter datapath; it is the consuming end of the filter's VOUT/DOUT stream.
- A stimulus source pushes golden output samples into an internal expected-value FIFO.
- The checker compares each valid filter output against the FIFO head, within a tolerance.
- It counts samples and mismatches, and raises END_SIM once the source has finished and all expected samples are consumed or a drain timeout expires.

---
 rtl/iir_out_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/iir_out_checker.sv
// Output-side checker for the IIR filter: compares each valid filter output against
// a FIFO of golden samples within a tolerance, counts samples and errors, and flags completion.
module iir_out_checker #(
    parameter int DW      = 9,
    parameter int DEPTH   = 16,
    parameter int TOL     = 1,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EXP_WR,
    input  logic [DW-1:0] EXP_DATA,
    input  logic          SMPL_END,
    input  logic          VIN,
    input  logic [DW-1:0] DIN,
    output logic          END_SIM,
    output logic          PASS,
    output logic [CW-1:0] SMPL_CNT,
    output logic [CW-1:0] ERR_CNT,
    output logic [CW-1:0] FIRST_ERR,
    output logic          OVF,
    output logic          TMO
);

    // state    | meaning
    // ST_IDLE  | waiting for the first golden sample or filter output
    // ST_RUN   | checking; source still issuing samples
    // ST_DRAIN | source finished; consuming remaining expected samples
    // ST_DONE  | terminal; counters frozen, result published

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [TW-1:0] idle_rem_q, idle_rem_d;
    logic [CW-1:0] smpl_cnt_q, smpl_cnt_d, err_cnt_q, err_cnt_d, first_err_q, first_err_d;
    logic          ovf_q, ovf_d, tmo_q, tmo_d, end_sim_q, end_sim_d, pass_q, pass_d;

    logic          active, in_drain, in_done;
    logic          empty, full, cmp, pop, push, bypass, unexp, drop, fail;
    logic          fifo_empty_nxt, idle_tc;
    logic [DW-1:0] ref_val;
    logic [DW:0]   diff, mag;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (EXP_WR || VIN) state_d = ST_RUN;
            ST_RUN:   if (SMPL_END) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty_nxt || idle_tc) state_d = ST_DONE;
            default:  state_d = ST_DONE;
        endcase
    end

    always_comb begin
        active   = (state_q != ST_DONE);
        in_drain = (state_q == ST_DRAIN);
        in_done  = (state_q == ST_DONE);
    end

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        cmp     = VIN && active;
        pop     = cmp && !empty;
        bypass  = cmp && empty && EXP_WR;
        unexp   = cmp && empty && !EXP_WR;
        push    = EXP_WR && active && !bypass && (!full || pop);
        drop    = EXP_WR && active && full && !pop;
        ref_val = empty ? EXP_DATA : mem_q[rd_ptr_q[AW-1:0]];
        // one extra bit keeps the difference exact across the full signed range
        diff    = {DIN[DW-1], DIN} - {ref_val[DW-1], ref_val};
        mag     = diff[DW] ? (~diff + 1'b1) : diff;
        fail    = unexp || (mag > (DW+1)'(TOL));

        wr_ptr_d       = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d       = rd_ptr_q + {{AW{1'b0}}, pop};
        fifo_empty_nxt = (wr_ptr_d == rd_ptr_d);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = EXP_DATA;
    end

    // drain watchdog: reloads on every output, terminal count ends the run
    always_comb begin
        idle_rem_d = idle_rem_q;
        if (!in_drain || VIN) begin
            idle_rem_d = TW'(TIMEOUT);
        end else if (idle_rem_q != '0) begin
            idle_rem_d = idle_rem_q - 1'b1;
        end
        idle_tc = in_drain && !VIN && (idle_rem_q == TW'(1));
    end

    always_comb begin
        smpl_cnt_d  = smpl_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (cmp && (smpl_cnt_q != '1)) smpl_cnt_d = smpl_cnt_q + 1'b1;
        if (cmp && fail) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (err_cnt_q == '0) first_err_d = smpl_cnt_q;
        end
        ovf_d     = ovf_q || drop;
        tmo_d     = tmo_q || (idle_tc && !fifo_empty_nxt);
        end_sim_d = end_sim_q || in_done;
        pass_d    = end_sim_q ? pass_q
                              : (in_done && (err_cnt_q == '0) && !ovf_q && !tmo_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            idle_rem_q  <= TW'(TIMEOUT);
            smpl_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            end_sim_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idle_rem_q  <= idle_rem_d;
            smpl_cnt_q  <= smpl_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            end_sim_q   <= end_sim_d;
            pass_q      <= pass_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign END_SIM   = end_sim_q;
    assign PASS      = pass_q;
    assign SMPL_CNT  = smpl_cnt_q;
    assign ERR_CNT   = err_cnt_q;
    assign FIRST_ERR = first_err_q;
    assign OVF       = ovf_q;
    assign TMO       = tmo_q;

endmodule
